// File: rtl/wb_neuron_master.sv
// Wishbone classic initiator for the neuron_core responder port.
// Commands are queued in a small FIFO and answered one response per command.
module wb_neuron_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                busy
);
    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] L_DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       L_TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic              r_fifo_we  [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_adr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_dat [FIFO_DEPTH];
    logic [SEL_W-1:0]  r_fifo_sel [FIFO_DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [7:0]        r_tmo;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              r_rsp_err;

    logic w_push;
    logic w_pop;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
    assign cmd_ready = (r_count != L_DEPTH);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]  <= cmd_we;
            r_fifo_adr[r_wr_ptr] <= cmd_adr;
            r_fifo_dat[r_wr_ptr] <= cmd_dat;
            r_fifo_sel[r_wr_ptr] <= cmd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmo     <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_we    <= r_fifo_we[r_rd_ptr];
                        r_adr   <= r_fifo_adr[r_rd_ptr];
                        r_dat   <= r_fifo_dat[r_rd_ptr];
                        r_sel   <= r_fifo_sel[r_rd_ptr];
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (wbm_ack_i) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_rsp_dat <= r_we ? '0 : wbm_dat_i;
                        r_rsp_err <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_tmo == L_TMO_LAST) begin
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_rsp_dat <= '0;
                        r_rsp_err <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: doc/wb_neuron_master.md
# wb_neuron_master

Wishbone classic initiator that drives the `neuron_core` Wishbone responder, i.e. the `wbs_*` port group of the core, from a simple valid/ready command stream. It buffers up to FIFO_DEPTH commands and issues one single-beat read or write per command. It returns one response per command, carrying read data or a timeout error. It sits between an on-chip sequencer/loader and `neuron_core`, replacing the management-SoC master in stand-alone test configurations.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; SEL width = DATA_W/8
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max cycles with stb high before abort (1..255)

- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADDR_W  byte address
- cmd_dat  in  DATA_W  write data
- cmd_sel  in  SEL  byte enables
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  1 = timed out
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls
- wbm_adr_o  out  ADDR_W;  wbm_dat_o  out  DATA_W;  wbm_sel_o  out  SEL
- wbm_dat_i  in  DATA_W;  wbm_ack_i  in  1
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Command FIFO: push on cmd_valid & cmd_ready. cmd_ready = !full, computed from the registered count only. A pop in the same cycle does not free a slot. No bypass: a push into an empty FIFO is visible only from the next cycle.
- FSM states: IDLE, REQ, RESP.
- IDLE: if FIFO non-empty, pop the head, register adr/dat/sel/we onto the wbm_* outputs, set cyc=stb=1, clear the timeout counter, and go to REQ.
- REQ: cyc, stb, and all wbm_* outputs are held constant. The timeout counter increments each cycle.
  - wbm_ack_i=1: capture wbm_dat_i into rsp_dat (reads) or 0 (writes), set rsp_err=0, drop cyc/stb, go to RESP.
  - Counter = TIMEOUT-1 and no ack: drop cyc/stb, set rsp_dat=0 and rsp_err=1, go to RESP.
  - Ack on the timeout cycle is treated as a normal ack.
- RESP: rsp_valid=1 and rsp_dat/rsp_err held stable. On rsp_ready go to IDLE. No new bus cycle starts until the response is consumed.
- wbm_ack_i outside REQ is ignored.
- wbm_we_o, wbm_adr_o, wbm_dat_o, and wbm_sel_o keep their last values when cyc=0.
- Reset: FIFO emptied, FSM to IDLE, timeout counter cleared. An in-flight bus cycle is abandoned: cyc/stb are low after the reset edge and no response is produced for it.

## Timing
- Reset values:
  - cyc, stb, we = 0; adr, dat, sel = 0
  - rsp_valid=0, rsp_dat=0, rsp_err=0
  - busy=0
  - cmd_ready=1 in the cycle after the reset edge
- Command accepted at edge N (FIFO empty, FSM IDLE) → cyc/stb high from edge N+1.
- Ack sampled high at edge M → cyc/stb low and rsp_valid high from edge M. Exactly one bus beat per command.
- rsp_ready sampled high at edge R → rsp_valid low from R. The next FIFO entry drives cyc high from R+1.
- Back-to-back throughput with a zero-wait responder (ack one cycle after stb) and rsp_ready tied high: 1 command per 4 cycles.
- Timeout: with no ack, stb is high for exactly TIMEOUT cycles.
- Commands are issued and answered strictly in FIFO order.

## Test plan
- Single write: cmd we=1, adr=0x3000_0010, dat=0xDEAD_BEEF, sel=0xF; responder acks 2 cycles after stb → wbm_* carry these values; one cycle with cyc·stb·ack; response rsp_err=0, rsp_dat=0.
- Single read: responder returns 0x1234_5678 with zero wait → rsp_dat=0x1234_5678, rsp_err=0; cyc high from the cycle after cmd accept.
- FIFO full: push 5 commands with rsp_ready=0 → cmd_ready low after 4 are buffered, plus the FSM holding the first transfer. All commands issue in order as responses drain. No command is lost or duplicated.
- Timeout: responder never acks, TIMEOUT=8 → stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0. The next command proceeds normally.
- Ack on the timeout cycle: ack asserted at count TIMEOUT-1 → normal response, rsp_err=0.
- Reset mid-transfer: rst during REQ with 2 commands queued → cyc/stb 0 after the edge, busy=0, rsp_valid never asserts; a new command after reset completes normally.
